// File: rtl/mul_seq_if.sv
// Handshake bundle for the sequential multiplier: operand channel in, product channel out.
interface mul_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier: magnitudes are multiplied one multiplier bit per clock,
// and the sign is reapplied to the final product.
module mul_seq #(
  parameter int WIDTH     = 8,
  parameter int ZERO_SKIP = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mul_seq_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic             neg;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    product_q;
  logic             valid_q;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // The most-negative operand negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    a_neg = bus.in_signed & bus.in_a[WIDTH-1];
    b_neg = bus.in_signed & bus.in_b[WIDTH-1];
    a_mag = a_neg ? (~bus.in_a + WIDTH'(1)) : bus.in_a;
    b_mag = b_neg ? (~bus.in_b + WIDTH'(1)) : bus.in_b;
  end

  always_comb begin
    acc_next = acc;
    if (mplier[count]) begin
      acc_next = acc + (PW'(mcand) << count);
    end
  end

  assign bus.in_ready    = (state == IDLE) && rst_n;
  assign bus.out_valid   = valid_q;
  assign bus.out_product = product_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      neg       <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      acc       <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            neg    <= a_neg ^ b_neg;
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            count  <= '0;
            if ((ZERO_SKIP != 0) && ((bus.in_a == '0) || (bus.in_b == '0))) begin
              product_q <= '0;
              valid_q   <= 1'b1;
              state     <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            product_q <= neg ? (~acc_next + PW'(1)) : acc_next;
            valid_q   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases on two instances (zero skip on/off)
// followed by a randomized stream compared against an arithmetic reference model.
module tb_mul_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_signed = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;

  int checks = 0;
  int passes = 0;

  logic [15:0] q[$];

  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(8)) bus0();
  mul_seq_if #(.WIDTH(8)) bus1();

  mul_seq #(.WIDTH(8), .ZERO_SKIP(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  mul_seq #(.WIDTH(8), .ZERO_SKIP(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  assign bus0.in_valid  = in_valid & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus0.in_signed = in_signed;
  assign bus1.in_signed = in_signed;
  assign bus0.in_a      = in_a;
  assign bus1.in_a      = in_a;
  assign bus0.in_b      = in_b;
  assign bus1.in_b      = in_b;
  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;

  wire        obs_ready   = sel ? bus1.in_ready    : bus0.in_ready;
  wire        obs_valid   = sel ? bus1.out_valid   : bus0.out_valid;
  wire [15:0] obs_product = sel ? bus1.out_product : bus0.out_product;

  // Reference: plain integer multiply of the operands as the mode interprets them.
  function automatic logic [15:0] refProduct(input logic s, input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    return 16'(x * y);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One full transaction with out_ready high: latency counted in edges after the accept edge.
  task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [7:0] b,
                               input int exp_edges, input logic [15:0] exp_prod, input string tag);
    int n;
    @(negedge clk);
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    n = 0;
    while (!obs_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ready"}, 32'(obs_ready), 1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_a      = 8'($urandom);
    in_b      = 8'($urandom);
    in_signed = ~s;
    checkOutput({tag, "_busy_ready"}, 32'(obs_ready), 0);
    n = 0;
    while (!obs_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, n, exp_edges);
    checkOutput({tag, "_product"}, 32'(obs_product), 32'(exp_prod));
    @(negedge clk);
    checkOutput({tag, "_retired"}, 32'(obs_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] held;
    logic [15:0] exp;
    int n;
    int sent;
    int got;
    int cyc;
    int stray;
    logic accepted;

    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(bus0.out_valid), 0);
    checkOutput("rst_product", 32'(bus0.out_product), 0);
    checkOutput("rst_ready_low", 32'(bus0.in_ready), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_ready_high", 32'(bus0.in_ready), 1);

    sel = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 8'd200, 8'd255, 8, 16'hC738, "unsigned");
    applyStimulus(1'b1, 8'hFD, 8'd5, 8, 16'hFFF1, "signed_neg");
    applyStimulus(1'b1, 8'h80, 8'h80, 8, 16'h4000, "signed_minmin");
    applyStimulus(1'b1, 8'h7F, 8'h80, 8, 16'hC080, "signed_maxmin");
    applyStimulus(1'b0, 8'd0, 8'd77, 0, 16'h0000, "zskip_on");
    sel = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd77, 8, 16'h0000, "zskip_off");
    sel = 1'b0;

    // Backpressure: result must hold and no new operands may be taken.
    out_ready = 1'b0;
    @(negedge clk);
    in_signed = 1'b0;
    in_a = 8'd12;
    in_b = 8'd13;
    in_valid = 1'b1;
    @(negedge clk);
    in_a = 8'd3;
    in_b = 8'd4;
    n = 0;
    while (!obs_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    held = obs_product;
    checkOutput("bp_product", 32'(held), 156);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", 32'(obs_valid), 1);
      checkOutput("bp_product_stable", 32'(obs_product), 32'(held));
      checkOutput("bp_no_accept", 32'(obs_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_retire_valid", 32'(obs_valid), 0);
    checkOutput("bp_retire_ready", 32'(obs_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_next_accept", 32'(obs_ready), 0);
    n = 0;
    while (!obs_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_next_product", 32'(obs_product), 12);
    @(negedge clk);

    // Abort a transaction with reset at its fourth busy cycle.
    @(negedge clk);
    in_signed = 1'b0;
    in_a = 8'd7;
    in_b = 8'd6;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", 32'(obs_valid), 0);
    checkOutput("abort_product", 32'(obs_product), 0);
    checkOutput("abort_ready_in_reset", 32'(obs_ready), 0);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (obs_valid) stray++;
    end
    checkOutput("abort_no_output", stray, 0);
    checkOutput("abort_idle", 32'(obs_ready), 1);
    applyStimulus(1'b0, 8'd9, 8'd9, 8, 16'd81, "abort_fresh");

    // Random stream with random backpressure.
    sent = 0;
    got = 0;
    cyc = 0;
    accepted = 1'b0;
    in_valid = 1'b0;
    while (got < 100 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (obs_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput("stream_extra", 32'(q.size()), 1);
        end else begin
          exp = q.pop_front();
          checkOutput("stream_product", 32'(obs_product), 32'(exp));
        end
        got++;
      end
      if (accepted) begin
        in_valid = 1'b0;
        accepted = 1'b0;
      end
      if (!in_valid && sent < 100 && $urandom_range(0, 2) != 0) begin
        in_signed = 1'($urandom_range(0, 1));
        in_a = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
        in_b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
        in_valid = 1'b1;
      end
      if (in_valid && obs_ready) begin
        q.push_back(refProduct(in_signed, in_a, in_b));
        sent++;
        accepted = 1'b1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", got, 100);
    checkOutput("stream_pending", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
